// File: rtl/backprop_hidden_delta_pkg.sv
// Shared Q5.10 constants, FSM state encoding and the saturation helper
// used by the hidden-neuron delta stage.
package backprop_hidden_delta_pkg;

    localparam int DWIDTH = 16;
    localparam int FRAC   = 10;

    localparam logic signed [DWIDTH-1:0] ONE_Q = 16'sh0400;
    localparam logic signed [DWIDTH-1:0] Q_MAX = 16'sh7FFF;
    localparam logic signed [DWIDTH-1:0] Q_MIN = 16'sh8000;

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        DERIV,
        SCALE,
        OUT
    } state_t;

    // Callers sign-extend their intermediate to 64 bits so one clamp serves every width.
    function automatic logic signed [DWIDTH-1:0] sat_q(input logic signed [63:0] v);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = {{(64-DWIDTH){Q_MAX[DWIDTH-1]}}, Q_MAX};
        lo = {{(64-DWIDTH){Q_MIN[DWIDTH-1]}}, Q_MIN};
        if (v > hi) begin
            sat_q = Q_MAX;
        end else if (v < lo) begin
            sat_q = Q_MIN;
        end else begin
            sat_q = v[DWIDTH-1:0];
        end
    endfunction

endpackage

// File: rtl/backprop_hidden_delta_if.sv
// Handshake bundle between the hidden-delta stage and its neighbours:
// start/activation, the (w, d) pair stream and the delta result.
interface backprop_hidden_delta_if;
    import backprop_hidden_delta_pkg::*;

    logic                     start;
    logic signed [DWIDTH-1:0] a_in;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DWIDTH-1:0] w_in;
    logic signed [DWIDTH-1:0] d_in;
    logic                     busy;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DWIDTH-1:0] delta_out;

    modport master (
        output start,
        output a_in,
        output in_valid,
        output w_in,
        output d_in,
        output out_ready,
        input  in_ready,
        input  busy,
        input  out_valid,
        input  delta_out
    );

    modport slave (
        input  start,
        input  a_in,
        input  in_valid,
        input  w_in,
        input  d_in,
        input  out_ready,
        output in_ready,
        output busy,
        output out_valid,
        output delta_out
    );

endinterface

// File: rtl/backprop_hidden_delta_fx_mul_sat.sv
// Combinational signed fixed-point multiply: full product, arithmetic shift
// by FRAC (truncating toward -inf), then clamp to one Q5.10 word.
module fx_mul_sat
    import backprop_hidden_delta_pkg::*;
#(
    parameter int AW = DWIDTH,
    parameter int BW = DWIDTH
) (
    input  logic signed [AW-1:0]     a,
    input  logic signed [BW-1:0]     b,
    output logic signed [DWIDTH-1:0] y
);

    localparam int PW = AW + BW;

    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] shifted;

    always_comb begin
        prod    = PW'(a) * PW'(b);
        shifted = prod >>> FRAC;
        y       = sat_q({{(64-PW){shifted[PW-1]}}, shifted});
    end

endmodule

// File: rtl/backprop_hidden_delta.sv
// Serial hidden-neuron delta: accumulates sum(w*d) over NTERM pairs, then
// delta_out = sat(sum * a*(a-1)) in Q5.10, returned over a valid/ready handshake.
module backprop_hidden_delta
    import backprop_hidden_delta_pkg::*;
#(
    parameter int NTERM = 4,
    parameter int ACCW  = 36
) (
    input logic                    clk,
    input logic                    rst,
    backprop_hidden_delta_if.slave bus
);

    localparam int CW = $clog2(NTERM + 1);
    localparam int PW = 2 * DWIDTH;

    state_t state;
    state_t state_next;

    logic signed [DWIDTH-1:0] a_reg;
    logic signed [DWIDTH-1:0] sum_reg;
    logic signed [DWIDTH-1:0] da_reg;
    logic signed [DWIDTH-1:0] delta_reg;
    logic signed [DWIDTH-1:0] da_calc;
    logic signed [DWIDTH-1:0] delta_calc;
    logic signed [ACCW-1:0]   acc;
    logic signed [ACCW-1:0]   acc_shifted;
    logic signed [PW-1:0]     pair_prod;
    logic signed [DWIDTH:0]   a_minus_one;
    logic [CW-1:0]            cnt;

    logic pair_xfer;
    logic out_xfer;
    logic last_pair;

    assign pair_xfer   = bus.in_valid && (state == ACCUM);
    assign out_xfer    = bus.out_ready && (state == OUT);
    assign last_pair   = pair_xfer && (cnt == CW'(NTERM - 1));
    assign pair_prod   = PW'(bus.w_in) * PW'(bus.d_in);
    assign acc_shifted = acc >>> FRAC;

    // One extra bit keeps a - 1.0 exact even for the most negative activation.
    assign a_minus_one = {a_reg[DWIDTH-1], a_reg} - {ONE_Q[DWIDTH-1], ONE_Q};

    fx_mul_sat #(
        .AW(DWIDTH),
        .BW(DWIDTH + 1)
    ) u_deriv (
        .a(a_reg),
        .b(a_minus_one),
        .y(da_calc)
    );

    fx_mul_sat #(
        .AW(DWIDTH),
        .BW(DWIDTH)
    ) u_scale (
        .a(sum_reg),
        .b(da_reg),
        .y(delta_calc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = ACCUM;
            ACCUM:   if (last_pair) state_next = DERIV;
            DERIV:   state_next = SCALE;
            SCALE:   state_next = OUT;
            OUT:     if (out_xfer) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath registers advance only in the state that owns them.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg     <= '0;
            acc       <= '0;
            cnt       <= '0;
            sum_reg   <= '0;
            da_reg    <= '0;
            delta_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_reg <= bus.a_in;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                ACCUM: begin
                    if (pair_xfer) begin
                        acc <= acc + {{(ACCW-PW){pair_prod[PW-1]}}, pair_prod};
                        cnt <= cnt + CW'(1);
                    end
                end
                DERIV: begin
                    sum_reg <= sat_q({{(64-ACCW){acc_shifted[ACCW-1]}}, acc_shifted});
                    da_reg  <= da_calc;
                end
                SCALE: begin
                    delta_reg <= delta_calc;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = (state == ACCUM);
    assign bus.busy      = (state != IDLE);
    assign bus.out_valid = (state == OUT);
    assign bus.delta_out = delta_reg;

endmodule

// File: tb/tb_backprop_hidden_delta.sv
// Directed and randomized checks of backprop_hidden_delta against an
// integer reference model of the Q5.10 hidden-delta formula.
module tb_backprop_hidden_delta;
    import backprop_hidden_delta_pkg::*;

    localparam int NT = 4;

    logic clk;
    logic rst;

    backprop_hidden_delta_if bus ();

    backprop_hidden_delta #(
        .NTERM(NT),
        .ACCW(36)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    logic [15:0] w_vec [NT];
    logic [15:0] d_vec [NT];

    function automatic longint satq(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // delta = sat(sat(sum >>> 10) * sat(a*(a-1.0) >>> 10) >>> 10), sum over the pair vectors.
    function automatic logic [15:0] refDelta(input logic [15:0] a);
        longint sum;
        longint s;
        longint av;
        longint da;
        sum = 0;
        for (int i = 0; i < NT; i++) begin
            sum += longint'($signed(w_vec[i])) * longint'($signed(d_vec[i]));
        end
        s  = satq(sum >>> 10);
        av = longint'($signed(a));
        da = satq((av * (av - 1024)) >>> 10);
        return 16'(satq((s * da) >>> 10));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_in_ready"},  16'(bus.in_ready),  16'h0);
        checkOutput({tag, "_out_valid"}, 16'(bus.out_valid), 16'h0);
        checkOutput({tag, "_busy"},      16'(bus.busy),      16'h0);
        checkOutput({tag, "_delta_out"}, bus.delta_out,      16'h0);
    endtask

    task automatic fillPairs(input logic [15:0] w, input logic [15:0] d);
        for (int i = 0; i < NT; i++) begin
            w_vec[i] = w;
            d_vec[i] = d;
        end
    endtask

    // Starts a neuron with activation a, streams w_vec/d_vec with optional gaps,
    // optionally pulses a bogus start mid-stream, and checks the 2-cycle latency.
    task automatic applyStimulus(input logic [15:0] a, input int gap, input bit poke_start);
        bus.a_in  = a;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checkOutput("busy_after_start", 16'(bus.busy), 16'h1);
        for (int i = 0; i < NT; i++) begin
            for (int g = 0; g < gap; g++) begin
                bus.in_valid = 1'b0;
                tick();
            end
            if (poke_start && i == 2) begin
                bus.in_valid = 1'b0;
                bus.a_in     = 16'h0000;
                bus.start    = 1'b1;
                tick();
                bus.start    = 1'b0;
            end
            checkOutput($sformatf("in_ready_pair%0d", i), 16'(bus.in_ready), 16'h1);
            bus.in_valid = 1'b1;
            bus.w_in     = w_vec[i];
            bus.d_in     = d_vec[i];
            tick();
            bus.in_valid = 1'b0;
        end
        checkOutput("latency_edge0", 16'(bus.out_valid), 16'h0);
        tick();
        checkOutput("latency_edge1", 16'(bus.out_valid), 16'h0);
        tick();
        checkOutput("latency_edge2", 16'(bus.out_valid), 16'h1);
    endtask

    // Checks the result, holds out_ready low for 'hold' cycles, then completes the transfer.
    task automatic drainOutput(input logic [15:0] expected, input int hold, input bit poke_start);
        checkOutput("delta_out", bus.delta_out, expected);
        bus.out_ready = 1'b0;
        for (int c = 0; c < hold; c++) begin
            bus.start = poke_start;
            bus.a_in  = 16'h0000;
            tick();
            bus.start = 1'b0;
            checkOutput($sformatf("hold%0d_valid", c), 16'(bus.out_valid), 16'h1);
            checkOutput($sformatf("hold%0d_delta", c), bus.delta_out, expected);
        end
        bus.out_ready = 1'b1;
        bus.start     = poke_start;
        tick();
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        checkOutput("out_valid_cleared", 16'(bus.out_valid), 16'h0);
        checkOutput("idle_after_out", 16'(bus.busy), 16'h0);
    endtask

    initial begin
        logic [15:0] a_rand;

        bus.start     = 1'b0;
        bus.a_in      = '0;
        bus.in_valid  = 1'b0;
        bus.w_in      = '0;
        bus.d_in      = '0;
        bus.out_ready = 1'b0;
        rst           = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        $display("[TB] reset state");
        checkReset("reset");

        $display("[TB] nominal a=0.5, w=1.0, d=0.5");
        fillPairs(16'h0400, 16'h0200);
        applyStimulus(16'h0200, 0, 1'b0);
        drainOutput(16'hFE00, 0, 1'b0);

        $display("[TB] zero derivative at a=1.0 and a=0");
        for (int i = 0; i < NT; i++) begin
            w_vec[i] = 16'($urandom_range(1, 16'h7FFF));
            d_vec[i] = 16'($urandom_range(1, 16'h7FFF));
        end
        applyStimulus(16'h0400, 0, 1'b0);
        drainOutput(16'h0000, 0, 1'b0);
        applyStimulus(16'h0000, 0, 1'b0);
        drainOutput(16'h0000, 0, 1'b0);

        $display("[TB] saturation of sum and of delta_out");
        fillPairs(16'h7FFF, 16'h7FFF);
        applyStimulus(16'h0200, 0, 1'b0);
        drainOutput(16'hE000, 0, 1'b0);
        fillPairs(16'h0400, 16'h0200);
        applyStimulus(16'hF000, 0, 1'b0);
        drainOutput(16'h7FFF, 0, 1'b0);

        $display("[TB] gaps, stalled output, stray starts");
        applyStimulus(16'h0200, 3, 1'b1);
        drainOutput(16'hFE00, 5, 1'b1);

        $display("[TB] reset mid-accumulation");
        bus.a_in  = 16'h0200;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.w_in     = 16'h7FFF;
            bus.d_in     = 16'h7FFF;
            tick();
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkReset("mid_reset");
        applyStimulus(16'h0200, 0, 1'b0);
        drainOutput(16'hFE00, 0, 1'b0);

        $display("[TB] back-to-back random neurons");
        for (int n = 0; n < 16; n++) begin
            a_rand = (n % 2 == 0) ? 16'($urandom_range(0, 16'h0400)) : 16'($urandom);
            for (int i = 0; i < NT; i++) begin
                w_vec[i] = 16'($urandom);
                d_vec[i] = (n % 4 == 1) ? 16'($urandom_range(0, 16'h0800)) : 16'($urandom);
            end
            applyStimulus(a_rand, 0, 1'b0);
            drainOutput(refDelta(a_rand), 0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
